// File: rtl/flat_buffer_readout.sv
// rtl/flat_buffer_readout.sv - snapshot a flat sample buffer and stream it out one element per transfer
// Optional feature: define FLAT_BUFFER_READOUT_LAST_EN to add the out_last port.
module flat_buffer_readout #(
  parameter int numChannels = 16,
  parameter int bitwidth    = 8,
  parameter int depth       = 5,
  localparam int NENT       = numChannels * depth,
  localparam int IW         = $clog2(NENT)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [bitwidth-1:0] flat_in [NENT-1:0],
  input  logic                capture,
  input  logic                out_ready,
  input  logic                ovf_clr,
  output logic [bitwidth-1:0] out_data,
  output logic [IW-1:0]       out_index,
`ifdef FLAT_BUFFER_READOUT_LAST_EN
  output logic                out_last,
`endif
  output logic                out_valid,
  output logic                busy,
  output logic                overflow
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NENT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [bitwidth-1:0] snap [NENT-1:0];

  logic xfer;
  logic last_xfer;
  logic reload;
  logic ovf_set;

  // A capture landing exactly on the final transfer chains straight into a new
  // snapshot; any other capture while streaming is dropped and flagged.
  assign xfer      = (state == STREAM) && out_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign reload    = capture && ((state == IDLE) || last_xfer);
  assign ovf_set   = capture && (state == STREAM) && !last_xfer;

  // Sequencer: snapshot capture, index advance and sticky overflow
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      idx      <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NENT; i++) begin
        snap[i] <= '0;
      end
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      if (reload) begin
        for (int i = 0; i < NENT; i++) begin
          snap[i] <= flat_in[i];
        end
        idx   <= '0;
        state <= STREAM;
      end else if (last_xfer) begin
        idx   <= '0;
        state <= IDLE;
      end else if (xfer) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Output mux reads only registered state, so flat_in never reaches out_data
  assign out_data  = snap[idx];
  assign out_index = idx;
  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);

`ifdef FLAT_BUFFER_READOUT_LAST_EN
  assign out_last  = (state == STREAM) && (idx == LAST_IDX);
`endif

endmodule

// File: tb/tb_flat_buffer_readout.sv
// tb/tb_flat_buffer_readout.sv - self-checking bench for flat_buffer_readout
module tb_flat_buffer_readout;

  localparam int NCH  = 16;
  localparam int BW   = 8;
  localparam int DEP  = 5;
  localparam int NENT = NCH * DEP;
  localparam int IW   = $clog2(NENT);

  logic          clk;
  logic          rstb;
  logic [BW-1:0] flat_in [NENT-1:0];
  logic          capture;
  logic          out_ready;
  logic          ovf_clr;
  logic [BW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_valid;
  logic          busy;
  logic          overflow;
`ifdef FLAT_BUFFER_READOUT_LAST_EN
  logic          out_last;
`endif

  int errors = 0;
  int checks = 0;

  flat_buffer_readout #(
    .numChannels(NCH),
    .bitwidth   (BW),
    .depth      (DEP)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .flat_in  (flat_in),
    .capture  (capture),
    .out_ready(out_ready),
    .ovf_clr  (ovf_clr),
    .out_data (out_data),
    .out_index(out_index),
`ifdef FLAT_BUFFER_READOUT_LAST_EN
    .out_last (out_last),
`endif
    .out_valid(out_valid),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a frozen copy of the buffer plus "how many elements have been handed over"
  int m_snap [NENT];
  int m_sent;
  bit m_active;
  bit m_ovf;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NENT; i++) m_snap[i] = 0;
      m_sent   = 0;
      m_active = 0;
      m_ovf    = 0;
    end else begin
      bit took;
      bit finished;
      took     = m_active && out_ready;
      finished = took && (m_sent == NENT - 1);
      if (capture && m_active && !finished) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (capture && (!m_active || finished)) begin
        for (int i = 0; i < NENT; i++) m_snap[i] = int'(flat_in[i]);
        m_sent   = 0;
        m_active = 1;
      end else if (finished) begin
        m_active = 0;
        m_sent   = 0;
      end else if (took) begin
        m_sent = m_sent + 1;
      end
    end
  end

  // Every-cycle comparison against the reference, away from the active edge
  always @(negedge clk) begin
    chk("valid", int'(out_valid), int'(m_active));
    chk("busy", int'(busy), int'(m_active));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (m_active) begin
      chk("index", int'(out_index), m_sent);
      chk("data", int'(out_data), m_snap[m_sent]);
    end
    if (!rstb) chk("reset_data", int'(out_data), 0);
`ifdef FLAT_BUFFER_READOUT_LAST_EN
    chk("last", int'(out_last), int'(m_active && (m_sent == NENT - 1)));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NENT; i++) flat_in[i] = BW'(i);
  endtask

  task automatic start();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  initial begin
    int got;
    rstb      = 1'b0;
    capture   = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    load_ramp();
    #23;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_index", int'(out_index), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    rstb = 1'b1;
    tick();

    // Plain ramp readout at full throughput
    start();
    for (int k = 0; k < NENT; k++) begin
      chk("ramp_index", int'(out_index), k);
      chk("ramp_data", int'(out_data), k);
      tick();
    end
    chk("ramp_end_valid", int'(out_valid), 0);

    // Alternating backpressure: 80 transfers over 160 cycles, in order
    start();
    got = 0;
    for (int c = 0; c < 2 * NENT; c++) begin
      out_ready = c[0];
      #1;
      if (out_valid && out_ready) begin
        chk("bp_data", int'(out_data), got);
        got++;
      end
      tick();
    end
    out_ready = 1'b1;
    chk("bp_count", got, NENT);
    chk("bp_end_valid", int'(out_valid), 0);

    // Upstream buffer scribbled mid-stream must not leak through
    start();
    for (int k = 0; k < NENT; k++) begin
      if (k == 10) for (int i = 0; i < NENT; i++) flat_in[i] = 8'hAA;
      chk("frozen_data", int'(out_data), k);
      tick();
    end
    load_ramp();

    // Dropped capture sets overflow; clear; simultaneous set beats clear
    start();
    for (int k = 0; k < NENT; k++) begin
      if (k == 40) capture = 1'b1;
      if (k == 41) begin
        capture = 1'b0;
        chk("ovf_set", int'(overflow), 1);
        ovf_clr = 1'b1;
      end
      if (k == 42) begin
        chk("ovf_clr", int'(overflow), 0);
        capture = 1'b1;
      end
      if (k == 43) begin
        capture = 1'b0;
        ovf_clr = 1'b0;
        chk("ovf_set_wins", int'(overflow), 1);
      end
      chk("ovf_stream_data", int'(out_data), k);
      tick();
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Back-to-back capture exactly on the last transfer
    start();
    for (int k = 0; k < NENT - 1; k++) tick();
    chk("b2b_pre_index", int'(out_index), NENT - 1);
    capture = 1'b1;
    for (int i = 0; i < NENT; i++) flat_in[i] = BW'(255 - i);
    tick();
    capture = 1'b0;
    chk("b2b_index", int'(out_index), 0);
    chk("b2b_data", int'(out_data), 255);
    chk("b2b_valid", int'(out_valid), 1);
    chk("b2b_ovf", int'(overflow), 0);
    for (int k = 0; k < NENT; k++) begin
      chk("b2b_stream", int'(out_data), 255 - k);
      tick();
    end
    chk("b2b_end_valid", int'(out_valid), 0);

    // Random traffic against the reference
    for (int c = 0; c < 4000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      capture   = ($urandom_range(0, 60) == 0);
      ovf_clr   = ($urandom_range(0, 20) == 0);
      if ($urandom_range(0, 7) == 0)
        for (int i = 0; i < NENT; i++) flat_in[i] = BW'($urandom);
      tick();
    end
    capture   = 1'b0;
    ovf_clr   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < NENT + 2; c++) tick();
    ovf_clr = 1'b0;
    load_ramp();

    // Reset in the middle of a stream
    start();
    for (int k = 0; k < 30; k++) tick();
    chk("pre_rst_index", int'(out_index), 30);
    #2;
    rstb = 1'b0;
    #1;
    chk("async_valid", int'(out_valid), 0);
    chk("async_data", int'(out_data), 0);
    chk("async_busy", int'(busy), 0);
    tick();
    tick();
    @(negedge clk);
    rstb = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_data", int'(out_data), 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
